// File: rtl/transformer_pkg.sv
// Types and size derivations shared by the pixel streamer and the transformer classifier.
package transformer_pkg;

   typedef enum logic [1:0] {IDLE, START, STREAM, WAIT} state_t;

   localparam int CLASS_W = 2;

   function automatic int addr_width(input int image_size);
      return $clog2(image_size * image_size);
   endfunction

   function automatic int patches(input int image_size, input int patch_size);
      return (image_size / patch_size) * (image_size / patch_size);
   endfunction

   function automatic int embed_dim(input int patch_size);
      return patch_size * patch_size;
   endfunction

endpackage

// File: rtl/patch_addr_gen.sv
// Patch-major read address generator: pixel column fastest, then pixel row,
// patch column, patch row.
module patch_addr_gen
   import transformer_pkg::*;
#(
   parameter int IMAGE_SIZE = 28,
   parameter int PATCH_SIZE = IMAGE_SIZE / 4,
   parameter int ADDR_W     = addr_width(IMAGE_SIZE)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              advance,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   localparam int GRID = IMAGE_SIZE / PATCH_SIZE;
   localparam int PW   = (PATCH_SIZE > 1) ? $clog2(PATCH_SIZE) : 1;
   localparam int GW   = (GRID > 1) ? $clog2(GRID) : 1;
   localparam logic [PW-1:0] PX_MAX = PW'(PATCH_SIZE - 1);
   localparam logic [GW-1:0] PT_MAX = GW'(GRID - 1);

   logic [PW-1:0] px_c, px_r;
   logic [GW-1:0] pt_c, pt_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         px_c <= '0;
         px_r <= '0;
         pt_c <= '0;
         pt_r <= '0;
      end else if (clear) begin
         px_c <= '0;
         px_r <= '0;
         pt_c <= '0;
         pt_r <= '0;
      end else if (advance) begin
         if (px_c != PX_MAX) begin
            px_c <= px_c + 1'b1;
         end else begin
            px_c <= '0;
            if (px_r != PX_MAX) begin
               px_r <= px_r + 1'b1;
            end else begin
               px_r <= '0;
               if (pt_c != PT_MAX) begin
                  pt_c <= pt_c + 1'b1;
               end else begin
                  pt_c <= '0;
                  pt_r <= (pt_r != PT_MAX) ? pt_r + 1'b1 : '0;
               end
            end
         end
      end
   end

   always_comb begin
      int row;
      int col;
      row  = int'(pt_r) * PATCH_SIZE + int'(px_r);
      col  = int'(pt_c) * PATCH_SIZE + int'(px_c);
      addr = ADDR_W'(row * IMAGE_SIZE + col);
      last = (px_c == PX_MAX) && (px_r == PX_MAX) && (pt_c == PT_MAX) && (pt_r == PT_MAX);
   end

endmodule

// File: rtl/image_patch_streamer.sv
// Host-side frame buffer that replays one image to the classifier in patch-major
// order, then returns the class (or a timeout) to the host.
module image_patch_streamer
   import transformer_pkg::*;
#(
   parameter int IMAGE_SIZE     = 28,
   parameter int PATCH_SIZE     = IMAGE_SIZE / 4,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int ADDR_W         = addr_width(IMAGE_SIZE)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               wr_en,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [7:0]         wr_data,
   input  logic               go,
   input  logic               pixel_en,
   output logic               busy,
   output logic               result_valid,
   output logic [CLASS_W-1:0] result_class,
   output logic               timeout,
   output logic               cls_start,
   output logic [7:0]         cls_pixel,
   output logic               cls_pixel_valid,
   input  logic               cls_ready,
   input  logic               cls_done,
   input  logic [CLASS_W-1:0] cls_class
);

   localparam int DEPTH = IMAGE_SIZE * IMAGE_SIZE;
   localparam int IDX_W = $clog2(DEPTH);
   localparam int TW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   state_t            state;
   logic [7:0]        frame [DEPTH];
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_last;
   logic [TW-1:0]     wait_cnt;
   logic              emit;

   // START doubles as the first streaming cycle so pixel 0 follows cls_start directly.
   assign emit = ((state == START) || (state == STREAM)) && pixel_en;

   patch_addr_gen #(
      .IMAGE_SIZE (IMAGE_SIZE),
      .PATCH_SIZE (PATCH_SIZE),
      .ADDR_W     (ADDR_W)
   ) u_addr_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (state == IDLE),
      .advance (emit),
      .addr    (rd_addr),
      .last    (rd_last)
   );

   // Frame contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if ((state == IDLE) && wr_en && (32'(wr_addr) < DEPTH))
         frame[IDX_W'(wr_addr)] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         busy            <= 1'b0;
         result_valid    <= 1'b0;
         result_class    <= '0;
         timeout         <= 1'b0;
         cls_start       <= 1'b0;
         cls_pixel       <= '0;
         cls_pixel_valid <= 1'b0;
         wait_cnt        <= '0;
      end else begin
         cls_start       <= 1'b0;
         result_valid    <= 1'b0;
         timeout         <= 1'b0;
         cls_pixel_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (go && cls_ready) begin
                  state     <= START;
                  busy      <= 1'b1;
                  cls_start <= 1'b1;
               end
            end
            START, STREAM: begin
               state <= STREAM;
               if (emit) begin
                  cls_pixel       <= frame[IDX_W'(rd_addr)];
                  cls_pixel_valid <= 1'b1;
                  if (rd_last) begin
                     state    <= WAIT;
                     wait_cnt <= '0;
                  end
               end
            end
            WAIT: begin
               if (cls_done) begin
                  result_class <= cls_class;
                  result_valid <= 1'b1;
                  busy         <= 1'b0;
                  state        <= IDLE;
               end else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                  timeout <= 1'b1;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_image_patch_streamer.sv
// Directed bench: a 4x4 instance for ordering, pacing, timeout, reset and write
// filtering, plus a default 28x28 instance for the full-frame round trip.
module tb_image_patch_streamer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic       rst_n, wr_en, go, pixel_en, cls_ready, cls_done;
   logic [4:0] wr_addr;
   logic [7:0] wr_data, cls_pixel;
   logic [1:0] cls_class, result_class;
   logic       busy, result_valid, timeout, cls_start, cls_pixel_valid;

   logic       d_wr_en, d_go, d_pixel_en, d_cls_ready, d_cls_done;
   logic [9:0] d_wr_addr;
   logic [7:0] d_wr_data, d_cls_pixel;
   logic [1:0] d_cls_class, d_result_class;
   logic       d_busy, d_result_valid, d_timeout, d_cls_start, d_cls_pixel_valid;

   image_patch_streamer #(
      .IMAGE_SIZE(4), .PATCH_SIZE(2), .TIMEOUT_CYCLES(16), .ADDR_W(5)
   ) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .go(go), .pixel_en(pixel_en), .busy(busy), .result_valid(result_valid),
      .result_class(result_class), .timeout(timeout), .cls_start(cls_start),
      .cls_pixel(cls_pixel), .cls_pixel_valid(cls_pixel_valid), .cls_ready(cls_ready),
      .cls_done(cls_done), .cls_class(cls_class)
   );

   image_patch_streamer dut_def (
      .clk(clk), .rst_n(rst_n), .wr_en(d_wr_en), .wr_addr(d_wr_addr), .wr_data(d_wr_data),
      .go(d_go), .pixel_en(d_pixel_en), .busy(d_busy), .result_valid(d_result_valid),
      .result_class(d_result_class), .timeout(d_timeout), .cls_start(d_cls_start),
      .cls_pixel(d_cls_pixel), .cls_pixel_valid(d_cls_pixel_valid), .cls_ready(d_cls_ready),
      .cls_done(d_cls_done), .cls_class(d_cls_class)
   );

   // Patch-major order of a 4x4 frame with 2x2 patches, holding mem[a] = a*3.
   int exp_seq [16] = '{0, 3, 12, 15, 6, 9, 18, 21, 24, 27, 36, 39, 30, 33, 42, 45};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic seen;
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; go = 1'b0; pixel_en = 1'b0;
      cls_ready = 1'b1; cls_done = 1'b0; cls_class = '0;
      d_wr_en = 1'b0; d_wr_addr = '0; d_wr_data = '0; d_go = 1'b0; d_pixel_en = 1'b0;
      d_cls_ready = 1'b1; d_cls_done = 1'b0; d_cls_class = '0;
      tick(); tick();

      chk("rst_busy", busy, 0);
      chk("rst_result_valid", result_valid, 0);
      chk("rst_result_class", result_class, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_cls_start", cls_start, 0);
      chk("rst_cls_pixel", cls_pixel, 0);
      chk("rst_cls_pixel_valid", cls_pixel_valid, 0);
      chk("rst_def_busy", d_busy, 0);
      rst_n = 1'b1;
      tick();

      for (int a = 0; a < 16; a++) begin
         wr_en = 1'b1; wr_addr = 5'(a); wr_data = 8'(a * 3);
         tick();
      end
      // Out-of-range address must not alias onto address 0.
      wr_addr = 5'd16; wr_data = 8'hAA;
      tick();
      wr_en = 1'b0;

      // Test 1: straight stream, then done.
      pixel_en = 1'b1; go = 1'b1;
      tick();
      go = 1'b0;
      chk("t1_cls_start", cls_start, 1);
      chk("t1_busy", busy, 1);
      chk("t1_no_pixel_on_start", cls_pixel_valid, 0);
      for (int i = 0; i < 16; i++) begin
         tick();
         chk($sformatf("t1_pixel%0d", i), {cls_pixel_valid, cls_pixel}, {1'b1, 8'(exp_seq[i])});
         chk($sformatf("t1_start_low%0d", i), cls_start, 0);
      end
      tick();
      chk("t1_wait_valid_low", cls_pixel_valid, 0);
      cls_done = 1'b1; cls_class = 2'd1;
      tick();
      cls_done = 1'b0;
      chk("t1_result_valid", result_valid, 1);
      chk("t1_result_class", result_class, 1);
      chk("t1_busy_low", busy, 0);
      tick();
      chk("t1_result_strobe", result_valid, 0);

      // Test 2/4: paced stream with a stray done, then timeout.
      go = 1'b1;
      tick();
      go = 1'b0;
      chk("t2_cls_start", cls_start, 1);
      for (int i = 0; i < 16; i++) begin
         pixel_en = 1'b1;
         tick();
         chk($sformatf("t2_pixel%0d", i), {cls_pixel_valid, cls_pixel}, {1'b1, 8'(exp_seq[i])});
         pixel_en = 1'b0;
         if (i == 5) cls_done = 1'b1;
         tick();
         cls_done = 1'b0;
         chk($sformatf("t2_gap%0d", i), cls_pixel_valid, 0);
         if (i == 5) chk("t4_stray_done", result_valid, 0);
      end
      seen = 1'b0;
      for (int k = 2; k <= 15; k++) begin
         tick();
         seen = seen | timeout | result_valid;
      end
      chk("t4_no_early_strobe", seen, 0);
      tick();
      chk("t4_timeout", timeout, 1);
      chk("t4_no_result", result_valid, 0);
      chk("t4_class_kept", result_class, 1);
      chk("t4_busy_low", busy, 0);
      tick();
      chk("t4_timeout_strobe", timeout, 0);

      // Test 5/6: writes during stream are dropped, async reset aborts.
      pixel_en = 1'b1; go = 1'b1;
      tick();
      go = 1'b0;
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 8'hFF;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk($sformatf("t5_pixel%0d", i), {cls_pixel_valid, cls_pixel}, {1'b1, 8'(exp_seq[i])});
      end
      wr_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_valid", cls_pixel_valid, 0);
      chk("t5_rst_pixel", cls_pixel, 0);
      chk("t5_rst_result_class", result_class, 0);
      chk("t5_rst_timeout", timeout, 0);
      tick();
      rst_n = 1'b1;
      go = 1'b1;
      tick();
      go = 1'b0;
      chk("t5_restart", cls_start, 1);
      for (int i = 0; i < 16; i++) begin
         tick();
         chk($sformatf("t5_replay%0d", i), {cls_pixel_valid, cls_pixel}, {1'b1, 8'(exp_seq[i])});
      end
      cls_done = 1'b1; cls_class = 2'd3;
      tick();
      cls_done = 1'b0;
      chk("t5_result_valid", result_valid, 1);
      chk("t5_result_class", result_class, 3);

      // Test 6: go without classifier ready.
      cls_ready = 1'b0; go = 1'b1;
      tick();
      chk("t6_no_start", cls_start, 0);
      chk("t6_no_busy", busy, 0);
      tick();
      chk("t6_still_idle", {busy, cls_start}, 0);
      go = 1'b0; cls_ready = 1'b1;

      // Test 3: default 28x28 configuration round trip.
      for (int a = 0; a < 784; a++) begin
         d_wr_en = 1'b1; d_wr_addr = 10'(a); d_wr_data = 8'(a * 7 + 1);
         tick();
      end
      d_wr_en = 1'b0;
      d_pixel_en = 1'b1; d_go = 1'b1;
      tick();
      d_go = 1'b0;
      chk("t3_cls_start", d_cls_start, 1);
      for (int pr = 0; pr < 4; pr++)
         for (int pc = 0; pc < 4; pc++)
            for (int xr = 0; xr < 7; xr++)
               for (int xc = 0; xc < 7; xc++) begin
                  int a;
                  a = (pr * 7 + xr) * 28 + pc * 7 + xc;
                  tick();
                  chk($sformatf("t3_pixel_addr%0d", a), {d_cls_pixel_valid, d_cls_pixel},
                      {1'b1, 8'(a * 7 + 1)});
               end
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         seen = seen | d_result_valid | d_cls_pixel_valid;
      end
      chk("t3_quiet_wait", seen, 0);
      d_cls_done = 1'b1; d_cls_class = 2'd2;
      tick();
      d_cls_done = 1'b0;
      chk("t3_result_valid", d_result_valid, 1);
      chk("t3_result_class", d_result_class, 2);
      chk("t3_busy_low", d_busy, 0);
      d_go = 1'b1;
      tick();
      d_go = 1'b0;
      chk("t3_second_go", {d_cls_start, d_busy}, 2'b11);
      chk("t3_result_strobe", d_result_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/image_patch_streamer.md
Name: image_patch_streamer

Overview:
Host-side feeder for the transformer classifier's pixel-stream input.
- Buffers one IMAGE_SIZE x IMAGE_SIZE 8-bit frame, written by the host in raster order.
- On command, issues the classifier start pulse and replays the frame in patch-major order (patches raster, pixels raster inside each patch).
- Waits for the classifier's done, then captures the class and returns it to the host with a one-cycle result strobe. A timeout guards against a hung classifier.

Parameters:
IMAGE_SIZE, 28, frame edge in pixels
PATCH_SIZE, IMAGE_SIZE/4, patch edge in pixels; must divide IMAGE_SIZE
TIMEOUT_CYCLES, 4096, max cycles in WAIT before abort
ADDR_W, $clog2(IMAGE_SIZE*IMAGE_SIZE), frame address width (derived)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  host frame write strobe
wr_addr  in  ADDR_W  raster address, row*IMAGE_SIZE+col
wr_data  in  8  pixel value
go  in  1  start one classification
pixel_en  in  1  pacing enable; low stalls streaming
busy  out  1  high from go acceptance until return to IDLE
result_valid  out  1  one-cycle strobe, result_class valid
result_class  out  2  captured class index
timeout  out  1  one-cycle strobe on WAIT timeout
cls_start  out  1  classifier start pulse
cls_pixel  out  8  pixel to classifier
cls_pixel_valid  out  1  pixel qualifier
cls_ready  in  1  classifier ready
cls_done  in  1  classifier done
cls_class  in  2  classifier result

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous active-low on rst_n. All control outputs are registered.
- Reset values: busy=0, result_valid=0, result_class=0, timeout=0, cls_start=0, cls_pixel=0, cls_pixel_valid=0, state=IDLE, all counters 0.
- The frame buffer is not reset. Contents survive rst_n.
- Reset asserted mid-operation aborts immediately: outputs return to reset values and no result or timeout strobe is emitted.
- States: IDLE, START, STREAM, WAIT.
- IDLE:
  - A write with wr_en=1 and wr_addr < IMAGE_SIZE^2 updates the buffer at the next edge. Out-of-range addresses are dropped.
  - go=1 and cls_ready=1 moves to START and sets busy=1.
  - go while cls_ready=0 is ignored; the block stays in IDLE.
- START: cls_start=1 for exactly one cycle, then STREAM. Writes are dropped in every non-IDLE state.
- STREAM:
  - Four counters: px_c, px_r (0..PATCH_SIZE-1) and pt_c, pt_r (0..IMAGE_SIZE/PATCH_SIZE-1). px_c is fastest, then px_r, then pt_c, then pt_r.
  - Read address = (pt_r*PATCH_SIZE+px_r)*IMAGE_SIZE + pt_c*PATCH_SIZE + px_c.
  - Each cycle with pixel_en=1: register cls_pixel=mem[addr] and cls_pixel_valid=1, then advance the counters.
  - Each cycle with pixel_en=0: cls_pixel_valid=0 and the counters hold.
  - After the pixel at counters all-max is emitted, go to WAIT. The timeout counter clears on entry.
  - cls_done seen during START or STREAM is ignored.
- WAIT:
  - cls_pixel_valid=0.
  - cls_done=1: result_class<=cls_class, result_valid=1 for one cycle, busy=0, go to IDLE.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT_CYCLES-1 without done: timeout=1 for one cycle, result_class unchanged, busy=0, go to IDLE.
  - cls_done and timeout in the same cycle: done wins.
- Latency with pixel_en tied high and go accepted at edge N:
  - cls_start is high in cycle N+1.
  - First valid pixel is in cycle N+2, the cycle the classifier first samples pixels.
  - Last pixel is in cycle N+1+IMAGE_SIZE^2.
  - Default configuration: 784 consecutive valid cycles.
- go received while busy is ignored. A new go is accepted in the cycle after result_valid or timeout.

Decomposition:
- Shared package transformer_pkg:
  - state enum (IDLE, START, STREAM, WAIT)
  - CLASS_W=2
  - a function computing ADDR_W
  - the PATCHES and EMBED_DIM derivations, shared with the classifier
- One sub-module, patch_addr_gen:
  - contains the four counters plus the address computation
  - inputs: clear, advance
  - outputs: addr, last
- The FSM, frame buffer and timeout counter stay in the top level.

Test Plan:
1. IMAGE_SIZE=4, PATCH_SIZE=2, buffer mem[a]=a*3, go with pixel_en high -> cls_start high for 1 cycle, then 16 consecutive valid pixels in address order 0,1,4,5,2,3,6,7,8,9,12,13,10,11,14,15, i.e. values 0,3,12,15,6,9,18,21,24,27,36,39,30,33,42,45.
2. Same config, pixel_en toggling 1,0,1,0 -> same 16 values with a gap between each. Valid is never high while pixel_en was low, and the counters do not skip.
3. Default config, classifier model returns cls_class=2 with done 5 cycles after the last pixel -> result_valid one cycle with result_class=2, then busy=0. A second go the next cycle is accepted.
4. TIMEOUT_CYCLES=16, done never asserted -> timeout strobe exactly 16 cycles after WAIT entry, no result_valid, result_class keeps its previous value. A cls_done pulse injected during STREAM causes no result.
5. rst_n pulsed low asynchronously at pixel 10 -> all outputs 0 immediately, state IDLE. The next go streams from pixel 0 with the buffer data intact.
6. wr_en during STREAM to address 0, and wr_addr=16 in IDLE with IMAGE_SIZE=4 -> both writes dropped; a subsequent stream shows the original data. go with cls_ready=0 -> no cls_start.
